// File: rtl/route_compute_unit.sv
// route_compute_unit: per-input-port route computation stage of the mesh router.
// It computes the output direction from each packet's head flit and latches that
// route for the body and tail flits. Flits and their routes are registered behind
// a single valid/ready stage. Misrouted or malformed flits are dropped and reported.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   in_data             flit: dest_x (top RRSIZE bits), dest_y (next RRSIZE bits), type [1:0]
//   congestion          per-direction busy hints {W,E,S,N}, used by west-first only
//   out_valid/out_ready downstream handshake
//   out_data            registered flit
//   out_vc_select       N 000, S 001, E 010, W 011, L 100, INVALID 111
//   out_head/out_tail   first / last flit of the packet
//   route_err           one-cycle pulse per dropped-with-error event
//   err_count           saturating error count
//   pkt_active          high while a routed packet is in progress
module route_compute_unit #(
  parameter int unsigned MSB_SLOT  = 5,
  parameter int unsigned DSIZE     = 1 << MSB_SLOT,
  parameter int unsigned RRSIZE    = 1 << (MSB_SLOT - 2),
  parameter int unsigned ALGORITHM = 0,
  parameter logic [2:0]  PORT      = 3'b100,
  parameter int unsigned ROUTER_X  = 0,
  parameter int unsigned ROUTER_Y  = 0,
  parameter int unsigned MESH_X    = 4,
  parameter int unsigned MESH_Y    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_data,
  input  logic [3:0]       congestion,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic [2:0]       out_vc_select,
  output logic             out_head,
  output logic             out_tail,
  output logic             route_err,
  output logic [7:0]       err_count,
  output logic             pkt_active
);

  localparam int unsigned CW = RRSIZE + 1;

  localparam logic [2:0] DIR_N   = 3'b000;
  localparam logic [2:0] DIR_S   = 3'b001;
  localparam logic [2:0] DIR_E   = 3'b010;
  localparam logic [2:0] DIR_W   = 3'b011;
  localparam logic [2:0] DIR_L   = 3'b100;
  localparam logic [2:0] DIR_INV = 3'b111;

  localparam logic [1:0] T_SINGLE = 2'b00;
  localparam logic [1:0] T_BODY   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_HEAD   = 2'b11;

  // Coordinates are compared one bit wider so that mesh sizes up to 2**RRSIZE fit.
  localparam logic [CW-1:0] RX = CW'(ROUTER_X);
  localparam logic [CW-1:0] RY = CW'(ROUTER_Y);
  localparam logic [CW-1:0] MX = CW'(MESH_X);
  localparam logic [CW-1:0] MY = CW'(MESH_Y);

  typedef enum logic [1:0] {IDLE, PACKET, DROP} state_t;

  state_t     state, state_n;
  logic [2:0] route_q;

  logic [CW-1:0] dest_x, dest_y;
  logic [1:0]    flit_type;
  logic          go_e, go_w, go_n, go_s;
  logic [2:0]    y_dir, route_c;
  logic          accept;
  logic          fwd_c, err_c, latch_c, head_c, tail_c;
  logic [2:0]    vc_c;

  // The west hint is never consulted: west-first never chooses west adaptively.
  logic unused_west_hint;
  assign unused_west_hint = congestion[3];

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign dest_x    = {1'b0, in_data[DSIZE-1 -: RRSIZE]};
  assign dest_y    = {1'b0, in_data[DSIZE-1-RRSIZE -: RRSIZE]};
  assign flit_type = in_data[1:0];

  // Route computation from the current in_data (Y grows southward).
  always_comb begin
    go_e    = dest_x > RX;
    go_w    = dest_x < RX;
    go_n    = dest_y < RY;
    go_s    = dest_y > RY;
    y_dir   = go_n ? DIR_N : DIR_S;
    route_c = DIR_L;
    if (ALGORITHM == 1) begin
      if (go_n || go_s) route_c = y_dir;
      else if (go_e)    route_c = DIR_E;
      else if (go_w)    route_c = DIR_W;
    end else if (ALGORITHM == 2) begin
      if (go_w) begin
        route_c = DIR_W;
      end else if (go_e && (go_n || go_s)) begin
        // Take the Y hop only when E is busy and the Y direction is not.
        if (congestion[2] && !(go_n ? congestion[0] : congestion[1])) route_c = y_dir;
        else                                                          route_c = DIR_E;
      end else if (go_e) begin
        route_c = DIR_E;
      end else if (go_n || go_s) begin
        route_c = y_dir;
      end
    end else begin
      if (go_e)              route_c = DIR_E;
      else if (go_w)         route_c = DIR_W;
      else if (go_n || go_s) route_c = y_dir;
    end
    if (dest_x >= MX || dest_y >= MY || route_c == PORT) route_c = DIR_INV;
  end

  // Per-flit decision: forward, drop, or drop with error; next packet state.
  always_comb begin
    state_n = state;
    fwd_c   = 1'b0;
    err_c   = 1'b0;
    latch_c = 1'b0;
    head_c  = 1'b0;
    tail_c  = 1'b0;
    vc_c    = route_q;
    if (accept) begin
      unique case (state)
        IDLE: begin
          if (flit_type == T_HEAD || flit_type == T_SINGLE) begin
            if (route_c == DIR_INV) begin
              err_c = 1'b1;
              if (flit_type == T_HEAD) state_n = DROP;
            end else begin
              fwd_c  = 1'b1;
              vc_c   = route_c;
              head_c = 1'b1;
              tail_c = (flit_type == T_SINGLE);
              if (flit_type == T_HEAD) begin
                latch_c = 1'b1;
                state_n = PACKET;
              end
            end
          end else begin
            err_c = 1'b1;
          end
        end
        PACKET: begin
          if (flit_type == T_BODY) begin
            fwd_c = 1'b1;
          end else if (flit_type == T_TAIL) begin
            fwd_c   = 1'b1;
            tail_c  = 1'b1;
            state_n = IDLE;
          end else begin
            err_c = 1'b1;
          end
        end
        DROP: begin
          if (flit_type == T_TAIL) state_n = IDLE;
          else if (flit_type == T_HEAD || flit_type == T_SINGLE) err_c = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, latched route and registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      route_q       <= DIR_INV;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_vc_select <= DIR_INV;
      out_head      <= 1'b0;
      out_tail      <= 1'b0;
      route_err     <= 1'b0;
      err_count     <= 8'd0;
      pkt_active    <= 1'b0;
    end else begin
      state      <= state_n;
      pkt_active <= (state_n == PACKET);
      route_err  <= err_c;
      if (err_c && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (latch_c) route_q <= route_c;
      if (in_ready) begin
        out_valid <= fwd_c;
        if (fwd_c) begin
          out_data      <= in_data;
          out_vc_select <= vc_c;
          out_head      <= head_c;
          out_tail      <= tail_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_route_compute_unit.sv
// Bench for route_compute_unit. Four instances with different algorithms, router
// positions and port codes run against a flit-level reference model. The directed
// scenarios come first, then randomized traffic with random backpressure.
module tb_route_compute_unit;

  localparam int N = 4;
  localparam int ALG [N] = '{0, 1, 2, 0};
  localparam int RXS [N] = '{2, 2, 1, 2};
  localparam int RYS [N] = '{2, 2, 1, 2};
  localparam int PRT [N] = '{3, 3, 4, 2};

  logic        clk = 1'b0;
  logic        reset;
  logic        iv    [N];
  logic [31:0] idat  [N];
  logic        ordy  [N];
  logic [3:0]  cong;
  logic        irdy  [N];
  logic        ov    [N];
  logic [31:0] od    [N];
  logic [2:0]  ovc   [N];
  logic        oh    [N];
  logic        ot    [N];
  logic        oerr  [N];
  logic [7:0]  ocnt  [N];
  logic        opkt  [N];

  // Reference model state
  int          mode   [N];   // 0 idle, 1 routing a packet, 2 discarding a packet
  logic [2:0]  eroute [N];
  logic        ev     [N];
  logic [31:0] ed     [N];
  logic [2:0]  evc    [N];
  logic        eh     [N];
  logic        et     [N];
  logic        eerr   [N];
  int          ecnt   [N];

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  route_compute_unit #(.ALGORITHM(0), .PORT(3'b011), .ROUTER_X(2), .ROUTER_Y(2)) u0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(idat[0]),
    .congestion(cong), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .out_vc_select(ovc[0]), .out_head(oh[0]), .out_tail(ot[0]), .route_err(oerr[0]),
    .err_count(ocnt[0]), .pkt_active(opkt[0]));
  route_compute_unit #(.ALGORITHM(1), .PORT(3'b011), .ROUTER_X(2), .ROUTER_Y(2)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(idat[1]),
    .congestion(cong), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .out_vc_select(ovc[1]), .out_head(oh[1]), .out_tail(ot[1]), .route_err(oerr[1]),
    .err_count(ocnt[1]), .pkt_active(opkt[1]));
  route_compute_unit #(.ALGORITHM(2), .PORT(3'b100), .ROUTER_X(1), .ROUTER_Y(1)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(idat[2]),
    .congestion(cong), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
    .out_vc_select(ovc[2]), .out_head(oh[2]), .out_tail(ot[2]), .route_err(oerr[2]),
    .err_count(ocnt[2]), .pkt_active(opkt[2]));
  route_compute_unit #(.ALGORITHM(0), .PORT(3'b010), .ROUTER_X(2), .ROUTER_Y(2)) u3 (
    .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(irdy[3]), .in_data(idat[3]),
    .congestion(cong), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]),
    .out_vc_select(ovc[3]), .out_head(oh[3]), .out_tail(ot[3]), .route_err(oerr[3]),
    .err_count(ocnt[3]), .pkt_active(opkt[3]));

  task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, u, obs, exp);
  endtask

  function automatic logic [31:0] flit(input int dx, input int dy, input int ty);
    logic [13:0] pl;
    pl = 14'($urandom);
    return {8'(dx), 8'(dy), pl, 2'(ty)};
  endfunction

  // Output direction for a destination, straight from the routing rules.
  function automatic logic [2:0] ref_route(input int u, input int dx, input int dy, input logic [3:0] cg);
    int x, y, ydir, d;
    x = RXS[u];
    y = RYS[u];
    if (dx >= 4 || dy >= 4) return 3'b111;
    ydir = (dy < y) ? 0 : 1;
    if (dx == x && dy == y)  d = 4;
    else if (ALG[u] == 0)    d = (dx > x) ? 2 : (dx < x) ? 3 : ydir;
    else if (ALG[u] == 1)    d = (dy != y) ? ydir : (dx > x) ? 2 : 3;
    else if (dx < x)         d = 3;
    else if (dx > x && dy != y) d = (cg[2] && !cg[ydir]) ? ydir : 2;
    else if (dx > x)         d = 2;
    else                     d = ydir;
    if (d == PRT[u]) return 3'b111;
    return 3'(d);
  endfunction

  task automatic model_reset();
    for (int u = 0; u < N; u++) begin
      mode[u] = 0; eroute[u] = 3'b111; ev[u] = 1'b0; ed[u] = '0; evc[u] = 3'b111;
      eh[u] = 1'b0; et[u] = 1'b0; eerr[u] = 1'b0; ecnt[u] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    for (int u = 0; u < N; u++) begin
      logic rdy, acc, fwd, err, h, t;
      logic [2:0] vc, rt;
      int ty;
      rdy = !ev[u] || ordy[u];
      acc = iv[u] && rdy;
      chk("in_ready", u, 32'(irdy[u]), 32'(rdy));
      fwd = 0; err = 0; h = 0; t = 0; vc = eroute[u];
      if (acc) begin
        ty = int'(idat[u][1:0]);
        rt = ref_route(u, int'(idat[u][31:24]), int'(idat[u][23:16]), cong);
        if (mode[u] == 0) begin
          if (ty == 3 || ty == 0) begin
            if (rt == 3'b111) begin
              err = 1;
              if (ty == 3) mode[u] = 2;
            end else begin
              fwd = 1; vc = rt; h = 1; t = (ty == 0);
              if (ty == 3) begin mode[u] = 1; eroute[u] = rt; end
            end
          end else err = 1;
        end else if (mode[u] == 1) begin
          if (ty == 1) fwd = 1;
          else if (ty == 2) begin fwd = 1; t = 1; mode[u] = 0; end
          else err = 1;
        end else begin
          if (ty == 2) mode[u] = 0;
          else if (ty == 3 || ty == 0) err = 1;
        end
      end
      eerr[u] = err;
      if (err && ecnt[u] < 255) ecnt[u]++;
      if (rdy) begin
        ev[u] = fwd;
        if (fwd) begin ed[u] = idat[u]; evc[u] = vc; eh[u] = h; et[u] = t; end
      end
    end
  endtask

  task automatic check_outs();
    for (int u = 0; u < N; u++) begin
      chk("out_valid", u, 32'(ov[u]), 32'(ev[u]));
      chk("out_data", u, od[u], ed[u]);
      chk("out_vc_select", u, 32'(ovc[u]), 32'(evc[u]));
      chk("out_head", u, 32'(oh[u]), 32'(eh[u]));
      chk("out_tail", u, 32'(ot[u]), 32'(et[u]));
      chk("route_err", u, 32'(oerr[u]), 32'(eerr[u]));
      chk("err_count", u, 32'(ocnt[u]), 32'(ecnt[u]));
      chk("pkt_active", u, 32'(opkt[u]), 32'(mode[u] == 1));
    end
  endtask

  task automatic tick();
    #1;
    model_clock();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic quiet();
    for (int u = 0; u < N; u++) begin iv[u] = 1'b0; ordy[u] = 1'b1; idat[u] = '0; end
  endtask

  task automatic send(input int u, input logic [31:0] d);
    iv[u] = 1'b1;
    idat[u] = d;
    tick();
    iv[u] = 1'b0;
  endtask

  initial begin
    quiet();
    cong  = 4'b0000;
    reset = 1'b1;
    model_reset();
    #3;
    check_outs();
    #9 reset = 1'b0;

    // XY, router (2,2), port W: packet to (3,1) goes east
    send(0, flit(3, 1, 3));
    chk("xy_head_vc", 0, 32'(ovc[0]), 32'd2);
    chk("xy_head_flag", 0, 32'(oh[0]), 32'd1);
    chk("xy_pkt_active", 0, 32'(opkt[0]), 32'd1);
    send(0, flit(0, 0, 1));
    send(0, flit(0, 0, 2));
    chk("xy_tail_flag", 0, 32'(ot[0]), 32'd1);
    chk("xy_tail_pkt_active", 0, 32'(opkt[0]), 32'd0);
    tick();

    // YX: (3,1) goes north, (2,2) is local
    send(1, flit(3, 1, 3));
    chk("yx_north", 1, 32'(ovc[1]), 32'd0);
    send(1, flit(0, 0, 2));
    send(1, flit(2, 2, 0));
    chk("yx_local", 1, 32'(ovc[1]), 32'd4);

    // West-first, router (1,1)
    cong = 4'b0100;
    send(2, flit(3, 3, 3));
    chk("wf_east_busy", 2, 32'(ovc[2]), 32'd1);
    send(2, flit(0, 0, 2));
    cong = 4'b0000;
    send(2, flit(3, 3, 3));
    chk("wf_idle", 2, 32'(ovc[2]), 32'd2);
    send(2, flit(0, 0, 2));
    cong = 4'b1111;
    send(2, flit(0, 3, 3));
    chk("wf_west", 2, 32'(ovc[2]), 32'd3);
    send(2, flit(0, 0, 2));
    cong = 4'b0000;

    // Port E, XY: routing back east is invalid; out-of-mesh is invalid
    send(3, flit(3, 2, 3));
    chk("inv_no_valid", 3, 32'(ov[3]), 32'd0);
    chk("inv_err", 3, 32'(oerr[3]), 32'd1);
    chk("inv_count", 3, 32'(ocnt[3]), 32'd1);
    send(3, flit(0, 0, 1));
    chk("inv_body_silent", 3, 32'(oerr[3]), 32'd0);
    send(3, flit(0, 0, 2));
    send(3, flit(1, 2, 3));
    chk("after_drop_routed", 3, 32'(ovc[3]), 32'd3);
    send(3, flit(0, 0, 2));
    send(3, flit(4, 0, 3));
    chk("oob_err", 3, 32'(oerr[3]), 32'd1);
    send(3, flit(0, 0, 2));

    // Backpressure mid-packet
    send(0, flit(3, 1, 3));
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    idat[0] = flit(1, 1, 1);
    for (int k = 0; k < 3; k++) tick();
    chk("bp_in_ready_low", 0, 32'(irdy[0]), 32'd0);
    ordy[0] = 1'b1;
    tick();
    idat[0] = flit(1, 1, 2);
    tick();
    iv[0] = 1'b0;
    tick();

    // Body flit while idle
    send(0, flit(0, 0, 1));
    chk("idle_body_err", 0, 32'(oerr[0]), 32'd1);

    // Reset in the middle of a packet
    send(0, flit(3, 1, 3));
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_outs();
    chk("rst_vc", 0, 32'(ovc[0]), 32'd7);
    #3 reset = 1'b0;
    send(0, flit(3, 1, 1));
    chk("post_rst_body_err", 0, 32'(oerr[0]), 32'd1);

    // Error counter saturation
    iv[0] = 1'b1;
    for (int k = 0; k < 260; k++) begin
      idat[0] = flit(0, 0, 1);
      tick();
    end
    iv[0] = 1'b0;
    chk("err_saturate", 0, 32'(ocnt[0]), 32'd255);

    // Randomized traffic with backpressure (after a reset to reuse the counter range)
    #2 reset = 1'b1;
    model_reset();
    #1 check_outs();
    #3 reset = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      cong = 4'($urandom);
      for (int u = 0; u < N; u++) begin
        iv[u]   = ($urandom_range(0, 3) != 0);
        ordy[u] = ($urandom_range(0, 3) != 0);
        idat[u] = flit($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
      end
      tick();
    end
    quiet();
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
